// File: rtl/pwm_pkg.sv
// Shared helpers for the PWM bank: counter terminal value and fetch-address width.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF = 3;
    localparam int NUM_PWM_DEF   = 4;

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    // thres_id keeps at least one bit even for a single channel
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [PWM_WIDTH_DEF-1:0]         thres_t;
    typedef logic [id_width(NUM_PWM_DEF)-1:0] thres_id_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow threshold captured during fetch, active threshold applied at wrap.
// PWM_OUT_INVERT_EN makes the output active-low.
module pwm_channel
#(
    parameter int pwm_width = 3
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic                 latch,
    input  logic [pwm_width-1:0] thres,
    input  logic [pwm_width-1:0] cnt,
    output logic                 pwm
);

    logic [pwm_width-1:0] shadow;
    logic [pwm_width-1:0] active;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (capture) shadow <= thres;
            if (latch)   active <= shadow;
        end
    end

`ifdef PWM_OUT_INVERT_EN
    assign pwm = ~(cnt < active);
`else
    assign pwm = (cnt < active);
`endif

endmodule

// File: rtl/pwm_bank.sv
// Bank of phase-aligned PWM channels sharing one period counter; thresholds fetched from
// external memory each period and applied together at the wrap. Honours PWM_OUT_INVERT_EN.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int pwm_width = 3,
    parameter int num_pwm   = 4
)
(
    input  logic                          clk,
    input  logic                          rst,
    output logic [id_width(num_pwm)-1:0]  thres_id,
    input  logic [pwm_width-1:0]          thres,
    output logic                          latch_mem,
    output logic [num_pwm-1:0]            pwm_out
);

    localparam int                   ID_W    = id_width(num_pwm);
    localparam logic [pwm_width-1:0] CNT_MAX = pwm_width'(cnt_max(pwm_width));
    localparam logic [pwm_width-1:0] CNT_PRE = pwm_width'(cnt_max(pwm_width) - 1);
    localparam logic [pwm_width-1:0] NUM_CNT = pwm_width'(num_pwm);

    if (num_pwm < 1 || num_pwm > cnt_max(pwm_width) - 1) begin : g_bad_num_pwm
        $error("pwm_bank: num_pwm out of range for pwm_width");
    end

    logic [pwm_width-1:0] cnt;
    logic                 latch_q;

    // latch_mem is registered one cycle ahead so it is high exactly while cnt==MAX
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            latch_q <= 1'b0;
        end else begin
            cnt     <= cnt + pwm_width'(1);
            latch_q <= (cnt == CNT_PRE);
        end
    end

    assign latch_mem = latch_q;
    assign thres_id  = (cnt < NUM_CNT) ? cnt[ID_W-1:0] : '0;

    // Channel j reads address j at cnt==j; memory data arrives while cnt==j+1
    for (genvar i = 0; i < num_pwm; i++) begin : g_ch
        pwm_channel #(
            .pwm_width (pwm_width)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .capture (cnt == pwm_width'(i + 1)),
            .latch   (cnt == CNT_MAX),
            .thres   (thres),
            .cnt     (cnt),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank (W=3, N=4) with a registered memory model and random reloads/resets.
module tb_pwm_bank;

    localparam int W = 3;
    localparam int N = 4;
    localparam int P = 8;

`ifdef PWM_OUT_INVERT_EN
    localparam logic [N-1:0] INV = '1;
`else
    localparam logic [N-1:0] INV = '0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   thres_id;
    logic [W-1:0] thres;
    logic         latch_mem;
    logic [N-1:0] pwm_out;

    always #5 clk = ~clk;

    pwm_bank #(.pwm_width(W), .num_pwm(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .thres_id  (thres_id),
        .thres     (thres),
        .latch_mem (latch_mem),
        .pwm_out   (pwm_out)
    );

    logic [W-1:0] mem [N];
    always @(posedge clk) thres <= mem[thres_id];

    typedef struct packed {
        logic [N-1:0] pwm;
        logic         latch;
        logic [1:0]   id;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset, duty per period from the memory image seen
    // during the previous period's fetch.
    int   m_t;
    bit   m_valid = 1'b0;
    int   m_active [N];
    int   m_fetched [N];
    logic r_samp;

    initial forever begin
        exp_t e;
        int   c;
        @(posedge clk);
        r_samp = rst;
        #1;
        if (r_samp) begin
            m_valid = 1'b1;
            m_t     = 0;
            for (int i = 0; i < N; i++) begin
                m_active[i]  = 0;
                m_fetched[i] = int'(mem[i]);
            end
        end else if (m_valid) begin
            m_t++;
            if (m_t % P == 0) begin
                for (int i = 0; i < N; i++) begin
                    m_active[i]  = m_fetched[i];
                    m_fetched[i] = int'(mem[i]);
                end
            end
        end
        if (m_valid) begin
            c = m_t % P;
            for (int i = 0; i < N; i++) e.pwm[i] = (c < m_active[i]) ^ INV[i];
            e.latch = (c == P - 1);
            e.id    = (c < N) ? 2'(c) : 2'd0;
            q.push_back(e);
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("pwm_out",   32'(pwm_out),   32'(e.pwm));
            check("latch_mem", 32'(latch_mem), 32'(e.latch));
            check("thres_id",  32'(thres_id),  32'(e.id));
        end
    end

    int hi_cnt [N];

    task automatic measure();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) hi_cnt[i] = 0;
        for (int c = 0; c < P; c++) begin
            @(negedge clk);
            v = pwm_out ^ INV;
            for (int i = 0; i < N; i++) hi_cnt[i] += int'(v[i]);
        end
    endtask

    task automatic check_duty(input string name, input int d0, input int d1, input int d2, input int d3);
        check({name, "_ch0"}, 32'(hi_cnt[0]), 32'(d0));
        check({name, "_ch1"}, 32'(hi_cnt[1]), 32'(d1));
        check({name, "_ch2"}, 32'(hi_cnt[2]), 32'(d2));
        check({name, "_ch3"}, 32'(hi_cnt[3]), 32'(d3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        n = 1;
        while (latch_mem !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("first_latch_cycle", 32'(n), 32'd8);
        mem[0] = 3'd1; mem[1] = 3'd7; mem[2] = 3'd4; mem[3] = 3'd2;

        measure();
        check_duty("duty_p2", 0, 0, 0, 0);
        measure();
        check_duty("duty_p3", 1, 7, 4, 2);
        mem[0] = 3'd0;
        measure();
        check_duty("duty_p4_old", 1, 7, 4, 2);
        measure();
        check_duty("duty_p5_new", 0, 7, 4, 2);

        n = 0;
        while ((m_t % P) != 5 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("reach_cnt5", 32'(m_t % P), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_pwm",   32'(pwm_out),   32'(INV));
        check("rst_latch", 32'(latch_mem), 32'd0);
        check("rst_id",    32'(thres_id),  32'd0);
        measure();
        measure();
        measure();

        repeat (800) begin
            @(negedge clk);
            rst = 1'b0;
            if (latch_mem === 1'b1 && $urandom_range(0, 1) == 1)
                for (int i = 0; i < N; i++) mem[i] = W'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
